// File: rtl/miss_fill_responder_pkg.sv
// Shared widths and record types for the miss path: the cache MSHR and the
// memory-side miss_fill_responder both import this package.
package miss_fill_responder_pkg;

  localparam int MSHR_DEPTH = 8;
  localparam int PADDR_W    = 15;
  localparam int PTCID_W    = 7;
  localparam int OFFS_W     = 4;
  localparam int LINE_W     = 128;

  typedef struct packed {
    logic [PADDR_W-1:0] paddr;
    logic [PTCID_W-1:0] ptcid;
    logic               rd_or_sw;
  } miss_req_t;

  typedef struct packed {
    miss_req_t         req;
    logic [LINE_W-1:0] data;
  } fill_t;

  localparam int MISS_REQ_W = $bits(miss_req_t);

  // Memory only understands whole lines, so the offset bits are forced to zero.
  function automatic logic [PADDR_W-1:0] line_align(input logic [PADDR_W-1:0] paddr);
    return {paddr[PADDR_W-1:OFFS_W], {OFFS_W{1'b0}}};
  endfunction

endpackage

// File: rtl/miss_slot_array.sv
// Pending-miss register file: request fields and line data are written by
// independent ports (accept and memory response); issue and retire read it.
module miss_slot_array
  import miss_fill_responder_pkg::*;
#(
  parameter int DEPTH = MSHR_DEPTH,
  localparam int IDX_W = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  clr,
  input  logic                  req_we,
  input  logic [IDX_W-1:0]      req_idx,
  input  logic [MISS_REQ_W-1:0] req_wdata,
  input  logic                  data_we,
  input  logic [IDX_W-1:0]      data_idx,
  input  logic [LINE_W-1:0]     data_wdata,
  input  logic [IDX_W-1:0]      iss_idx,
  output logic [PADDR_W-1:0]    iss_paddr,
  input  logic [IDX_W-1:0]      ret_idx,
  output logic [MISS_REQ_W-1:0] ret_req,
  output logic [LINE_W-1:0]     ret_data,
  output logic                  ret_has_data
);

  miss_req_t         req_mem_r  [DEPTH];
  logic [LINE_W-1:0] data_mem_r [DEPTH];
  logic [DEPTH-1:0]  has_data_r;

  // Slot storage; the two write ports never target the same slot because a
  // response only lands on an already issued entry while accept fills a free one.
  always_ff @(posedge clk) begin
    if (clr) begin
      for (int i = 0; i < DEPTH; i++) begin
        req_mem_r[i]  <= '0;
        data_mem_r[i] <= '0;
      end
      has_data_r <= '0;
    end else begin
      if (req_we) begin
        req_mem_r[req_idx]  <= req_wdata;
        has_data_r[req_idx] <= 1'b0;
      end
      if (data_we) begin
        data_mem_r[data_idx] <= data_wdata;
        has_data_r[data_idx] <= 1'b1;
      end
    end
  end

  assign iss_paddr    = req_mem_r[iss_idx].paddr;
  assign ret_req      = req_mem_r[ret_idx];
  assign ret_data     = data_mem_r[ret_idx];
  assign ret_has_data = has_data_r[ret_idx];

endmodule

// File: rtl/miss_fill_responder.sv
// Memory-side half of the MSHR: queues line misses, issues them to memory in
// order, pairs in-order responses back up and hands fills to the cache.
module miss_fill_responder
  import miss_fill_responder_pkg::*;
#(
  parameter int DEPTH = MSHR_DEPTH
) (
  input  logic               clk,
  input  logic               clr,
  input  logic               req_valid,
  output logic               req_ready,
  input  logic [PADDR_W-1:0] req_paddr,
  input  logic [PTCID_W-1:0] req_ptcid,
  input  logic               req_rd_or_sw,
  output logic               mem_req_valid,
  input  logic               mem_req_ready,
  output logic [PADDR_W-1:0] mem_req_paddr,
  input  logic               mem_resp_valid,
  input  logic [LINE_W-1:0]  mem_resp_data,
  output logic               fill_valid,
  input  logic               fill_ready,
  output logic [PADDR_W-1:0] fill_paddr,
  output logic [PTCID_W-1:0] fill_ptcid,
  output logic               fill_rd_or_sw,
  output logic [LINE_W-1:0]  fill_data,
  output logic               dealloc,
  output logic               resp_err
);

  localparam int IDX_W = $clog2(DEPTH);
  localparam int PTR_W = IDX_W + 1;
  localparam logic [PTR_W-1:0] PTR_ONE  = {{IDX_W{1'b0}}, 1'b1};
  localparam logic [PTR_W-1:0] FULL_CNT = {1'b1, {IDX_W{1'b0}}};

  logic [PTR_W-1:0]   wr_ptr_r;
  logic [PTR_W-1:0]   iss_ptr_r;
  logic [PTR_W-1:0]   rsp_ptr_r;
  logic [PTR_W-1:0]   ret_ptr_r;
  logic [PTR_W-1:0]   cnt_s;
  logic               resp_err_r;

  logic               accept_s;
  logic               issue_s;
  logic               rsp_hit_s;
  logic               rsp_orphan_s;
  logic               retire_s;

  miss_req_t          acc_req_s;
  miss_req_t          ret_req_s;
  fill_t              fill_s;
  logic [PADDR_W-1:0] iss_paddr_s;
  logic [LINE_W-1:0]  ret_data_s;
  logic               ret_has_data_s;

  // Extra pointer bit distinguishes full from empty when the slot indices match.
  assign cnt_s         = wr_ptr_r - ret_ptr_r;
  assign req_ready     = (cnt_s != FULL_CNT);
  assign mem_req_valid = (iss_ptr_r != wr_ptr_r);
  assign mem_req_paddr = line_align(iss_paddr_s);
  assign fill_valid    = (ret_ptr_r != rsp_ptr_r) & ret_has_data_s;
  assign dealloc       = fill_valid & fill_ready;
  assign resp_err      = resp_err_r;

  assign accept_s      = req_valid & req_ready;
  assign issue_s       = mem_req_valid & mem_req_ready;
  assign rsp_hit_s     = mem_resp_valid & (rsp_ptr_r != iss_ptr_r);
  assign rsp_orphan_s  = mem_resp_valid & (rsp_ptr_r == iss_ptr_r);
  assign retire_s      = dealloc;

  assign acc_req_s = '{paddr: req_paddr, ptcid: req_ptcid, rd_or_sw: req_rd_or_sw};
  assign fill_s    = '{req: ret_req_s, data: ret_data_s};

  assign fill_paddr    = fill_s.req.paddr;
  assign fill_ptcid    = fill_s.req.ptcid;
  assign fill_rd_or_sw = fill_s.req.rd_or_sw;
  assign fill_data     = fill_s.data;

  // Queue pointers; each advances on its own handshake, all in the same cycle if need be.
  always_ff @(posedge clk) begin
    if (clr) begin
      wr_ptr_r  <= '0;
      iss_ptr_r <= '0;
      rsp_ptr_r <= '0;
      ret_ptr_r <= '0;
    end else begin
      if (accept_s) begin
        wr_ptr_r <= wr_ptr_r + PTR_ONE;
      end
      if (issue_s) begin
        iss_ptr_r <= iss_ptr_r + PTR_ONE;
      end
      if (rsp_hit_s) begin
        rsp_ptr_r <= rsp_ptr_r + PTR_ONE;
      end
      if (retire_s) begin
        ret_ptr_r <= ret_ptr_r + PTR_ONE;
      end
    end
  end

  // Sticky flag for responses with nothing outstanding, e.g. stragglers after clr.
  always_ff @(posedge clk) begin
    if (clr) begin
      resp_err_r <= 1'b0;
    end else if (rsp_orphan_s) begin
      resp_err_r <= 1'b1;
    end
  end

  miss_slot_array #(
    .DEPTH(DEPTH)
  ) u_slots (
    .clk          (clk),
    .clr          (clr),
    .req_we       (accept_s),
    .req_idx      (wr_ptr_r[IDX_W-1:0]),
    .req_wdata    (acc_req_s),
    .data_we      (rsp_hit_s),
    .data_idx     (rsp_ptr_r[IDX_W-1:0]),
    .data_wdata   (mem_resp_data),
    .iss_idx      (iss_ptr_r[IDX_W-1:0]),
    .iss_paddr    (iss_paddr_s),
    .ret_idx      (ret_ptr_r[IDX_W-1:0]),
    .ret_req      (ret_req_s),
    .ret_data     (ret_data_s),
    .ret_has_data (ret_has_data_s)
  );

endmodule
